// File: rtl/pin_bus_bridge.sv
// pin_bus_bridge: frames each CPU access as cmd/addr/wdata beats on a narrow pad bus,
// then collects flow-controlled read beats or a write commit, with a pin_rdy timeout.
// Ports: clk, rst_n (async active-low);
//        cpu_req/cpu_we/cpu_addr/cpu_wdata in, cpu_busy/cpu_ack/cpu_err/cpu_rdata out;
//        pin_out/pin_oe/pin_strb drive the pads, pin_in/pin_rdy come back from them.
module pin_bus_bridge #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int PIN_W    = 8,
  parameter int TURN_CYC = 1,
  parameter int TIMEOUT  = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_busy,
  output logic              cpu_ack,
  output logic              cpu_err,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic [PIN_W-1:0]  pin_out,
  output logic [PIN_W-1:0]  pin_oe,
  output logic              pin_strb,
  input  logic [PIN_W-1:0]  pin_in,
  input  logic              pin_rdy
);
  localparam int AB = ADDR_W / PIN_W;
  localparam int DB = DATA_W / PIN_W;
  localparam int MB = (AB > DB) ? ((AB > TURN_CYC) ? AB : TURN_CYC) : ((DB > TURN_CYC) ? DB : TURN_CYC);
  localparam int CW = $clog2(MB) + 1;
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  typedef enum logic [2:0] {IDLE, CMD, ADDR, WDATA, TURN, WAIT, RDATA, DONE} state_t;
  state_t state, state_nx;
  logic [CW-1:0] beat;
  logic [TW-1:0] to_cnt;
  logic we_q, err_q, miss, tmo, drive;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rd_q, rd_nx;
  always_comb begin
    state_nx = state;
    miss = (state == WAIT || state == RDATA) && !pin_rdy;
    // timeout fires on the TIMEOUT-th consecutive miss
    tmo = (TIMEOUT > 0) && miss && to_cnt == TW'(TIMEOUT - 1);
    // read beats enter at the top and shift down, so beat 0 ends up in the LSB slice
    rd_nx = (rd_q >> PIN_W) | (DATA_W'(pin_in) << (DATA_W - PIN_W));
    case (state)
      IDLE:    if (cpu_req) state_nx = CMD;
      CMD:     state_nx = ADDR;
      ADDR:    if (beat == CW'(AB - 1)) state_nx = we_q ? WDATA : TURN;
      WDATA:   if (beat == CW'(DB - 1)) state_nx = WAIT;
      TURN:    if (beat == CW'(TURN_CYC - 1)) state_nx = RDATA;
      WAIT:    if (pin_rdy || tmo) state_nx = DONE;
      RDATA:   if ((pin_rdy && beat == CW'(DB - 1)) || tmo) state_nx = DONE;
      default: state_nx = IDLE;
    endcase
    drive = state == CMD || state == ADDR || state == WDATA;
    pin_oe = {PIN_W{drive}};
    pin_strb = drive;
    pin_out = state == CMD ? PIN_W'({we_q, 1'b1}) :
              state == ADDR ? addr_q[PIN_W-1:0] :
              state == WDATA ? wdata_q[PIN_W-1:0] : '0;
    cpu_busy = state != IDLE;
    cpu_ack = state == DONE;
    cpu_err = state == DONE && err_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      beat <= '0;
      to_cnt <= '0;
      we_q <= 1'b0;
      err_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      rd_q <= '0;
      cpu_rdata <= '0;
    end else begin
      state <= state_nx;
      beat <= (state_nx != state) ? '0 : (state == RDATA ? beat + CW'(pin_rdy) : beat + CW'(1));
      to_cnt <= (state_nx != state || !miss) ? '0 : to_cnt + TW'(1);
      if (state == IDLE && cpu_req) begin
        we_q <= cpu_we;
        addr_q <= cpu_addr;
        wdata_q <= cpu_wdata;
        err_q <= 1'b0;
      end
      if (state == ADDR) addr_q <= addr_q >> PIN_W;
      if (state == WDATA) wdata_q <= wdata_q >> PIN_W;
      if (state == RDATA && pin_rdy) rd_q <= rd_nx;
      if (tmo) err_q <= 1'b1;
      // rdata is loaded on the way into DONE so it is valid alongside cpu_ack
      if (state_nx == DONE && state != DONE && (!we_q || tmo)) cpu_rdata <= tmo ? '0 : rd_nx;
    end
  end
endmodule

// File: tb/tb_pin_bus_bridge.sv
// tb_pin_bus_bridge: directed checks of pin_bus_bridge framing, reads, stalls, timeout and reset.
module tb_pin_bus_bridge;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic cpu_req = 1'b0, cpu_we = 1'b0, pin_rdy = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic [7:0] pin_in = '0;
  logic cpu_busy, cpu_ack, cpu_err, pin_strb;
  logic [31:0] cpu_rdata;
  logic [7:0] pin_out, pin_oe;
  logic busy0, ack0, err0, strb0;
  logic [31:0] rdata0;
  logic [7:0] pin_out0, oe0;
  int vectors = 0, miscompares = 0;
  always #5 clk = ~clk;
  pin_bus_bridge dut (
    .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_busy(cpu_busy), .cpu_ack(cpu_ack), .cpu_err(cpu_err),
    .cpu_rdata(cpu_rdata), .pin_out(pin_out), .pin_oe(pin_oe), .pin_strb(pin_strb),
    .pin_in(pin_in), .pin_rdy(pin_rdy)
  );
  pin_bus_bridge #(.TIMEOUT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_busy(busy0), .cpu_ack(ack0), .cpu_err(err0),
    .cpu_rdata(rdata0), .pin_out(pin_out0), .pin_oe(oe0), .pin_strb(strb0),
    .pin_in(pin_in), .pin_rdy(pin_rdy)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  initial begin
    logic [7:0] wexp [9] = '{8'h03, 8'h78, 8'h56, 8'h34, 8'h12, 8'h0D, 8'hF0, 8'hFE, 8'hCA};
    logic [7:0] rexp [5] = '{8'h01, 8'h10, 8'h00, 8'h00, 8'h00};
    logic [7:0] rin [4] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    logic srdy [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [7:0] sdat [7] = '{8'h11, 8'h22, 8'hAA, 8'hAA, 8'hAA, 8'h33, 8'h44};
    int strb_n, acks, acks0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_out", {cpu_busy, cpu_ack, cpu_err, pin_strb, pin_oe, pin_out, cpu_rdata}, 64'd0);
    tick;
    tick;
    chk("rst_out", {cpu_busy, cpu_ack, cpu_err, pin_strb, pin_oe, pin_out, cpu_rdata}, 64'd0);
    chk("rst_out0", {busy0, ack0, err0, strb0, oe0, pin_out0, rdata0}, 64'd0);
    rst_n = 1'b1;
    // write 0x12345678 <- 0xCAFEF00D, commit immediately
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h12345678; cpu_wdata = 32'hCAFEF00D; pin_rdy = 1'b1;
    strb_n = 0;
    for (int c = 1; c <= 12; c++) begin
      tick;
      cpu_req = 1'b0;
      strb_n += int'(pin_strb);
      if (c <= 9) chk($sformatf("wr_pin%0d", c), {pin_oe, pin_out}, {8'hFF, wexp[c-1]});
      chk($sformatf("wr_ack%0d", c), cpu_ack, c == 11);
      if (c == 11) chk("wr_err", cpu_err, 1'b0);
      if (c == 12) chk("wr_idle", cpu_busy, 1'b0);
    end
    chk("wr_strb_cnt", strb_n, 9);
    // read 0x10, pin_rdy high throughout
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h00000010;
    for (int c = 1; c <= 11; c++) begin
      tick;
      cpu_req = 1'b0;
      if (c <= 5) chk($sformatf("rd_pin%0d", c), pin_out, rexp[c-1]);
      if (c == 6) chk("rd_turn_oe", {pin_oe, pin_strb, pin_out}, 17'd0);
      if (c >= 7 && c <= 10) pin_in = rin[c-7];
      chk($sformatf("rd_ack%0d", c), cpu_ack, c == 11);
      if (c == 11) chk("rd_data", {cpu_err, cpu_rdata}, {1'b0, 32'hDEADBEEF});
    end
    // read with 3 stall cycles between beats 1 and 2; garbage on pin_in while stalled
    tick;
    cpu_req = 1'b1; cpu_addr = 32'h00000020;
    for (int c = 1; c <= 14; c++) begin
      tick;
      cpu_req = 1'b0;
      if (c >= 7 && c <= 13) begin
        pin_rdy = srdy[c-7];
        pin_in = sdat[c-7];
      end
      if (c == 14) pin_rdy = 1'b1;
      chk($sformatf("st_ack%0d", c), cpu_ack, c == 14);
      if (c == 14) chk("st_data", {cpu_err, cpu_rdata}, {1'b0, 32'h44332211});
    end
    // requests while busy and in DONE are ignored
    tick;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h55667788; cpu_wdata = 32'h123456EF;
    for (int c = 1; c <= 15; c++) begin
      tick;
      cpu_req = (c == 3 || c >= 11 && c <= 12);
      if (c == 3) begin cpu_we = 1'b0; cpu_addr = 32'hFFFFFFFF; cpu_wdata = '0; end
      if (c == 11) begin cpu_we = 1'b0; cpu_addr = 32'h00000010; end
      if (c == 4) chk("ig_addr_b2", pin_out, 8'h66);
      if (c == 6) chk("ig_wdata_b0", pin_out, 8'hEF);
      if (c == 11) chk("ig_ack", cpu_ack, 1'b1);
      if (c == 12) chk("ig_done_req", cpu_busy, 1'b0);
      if (c == 13) chk("ig_next_cmd", {cpu_busy, pin_out}, {1'b1, 8'h01});
    end
    // cycle 15 is the second ADDR beat of the read: reset asynchronously
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out", {cpu_busy, cpu_ack, pin_strb, pin_oe}, 11'd0);
    tick;
    tick;
    rst_n = 1'b1;
    acks = 0;
    for (int c = 0; c < 4; c++) begin
      tick;
      acks += int'(cpu_ack) + int'(cpu_busy);
    end
    chk("mid_rst_no_ack", acks, 0);
    // write with pin_rdy held low: timeout at 255 misses; TIMEOUT=0 copy never finishes
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'hA0A0A0A0; cpu_wdata = 32'h0; pin_rdy = 1'b0;
    tick;
    cpu_req = 1'b0;
    chk("to_cmd", {cpu_busy, pin_out}, {1'b1, 8'h03});
    acks = 0;
    acks0 = 0;
    for (int c = 2; c <= 300; c++) begin
      tick;
      acks0 += int'(ack0);
      if (c < 265) acks += int'(cpu_ack);
      if (c == 10) chk("to_wait_oe", pin_oe, 8'h00);
      if (c == 265) chk("to_ack_err", {cpu_ack, cpu_err}, 2'b11);
      if (c == 266) chk("to_idle", {cpu_busy, cpu_ack}, 2'b00);
    end
    chk("to_no_early_ack", acks, 0);
    chk("to0_no_ack", acks0, 0);
    chk("to0_busy", busy0, 1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
